// File: rtl/pico_io_pkg.sv
// Shared constants and types for the pico_io_hub KCPSM6 I/O and interrupt subsystem.
package pico_io_pkg;

    // Default special-port addresses
    localparam logic [7:0] IRQ_STATUS_PORT_DEF = 8'hF0;
    localparam logic [7:0] IRQ_MASK_PORT_DEF   = 8'hF1;
    localparam logic [7:0] WDOG_PORT_DEF       = 8'hF2;

    // Number of clk cycles the watchdog reset request stays high
    localparam int WDOG_PULSE_LEN = 16;

    // Interrupt handshake states
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } irq_state_e;

endpackage

// File: rtl/pico_io_hub_if.sv
// KCPSM6 port bus: address, strobes, data in both directions and the interrupt handshake.
interface pico_io_hub_if;

    logic [7:0] port_id;
    logic       write_strobe;
    logic       k_write_strobe;
    logic       read_strobe;
    logic [7:0] out_port;
    logic [7:0] in_port;
    logic       interrupt;
    logic       interrupt_ack;

    // Processor side
    modport master (
        output port_id, write_strobe, k_write_strobe, read_strobe, out_port, interrupt_ack,
        input  in_port, interrupt
    );

    // Peripheral side
    modport slave (
        input  port_id, write_strobe, k_write_strobe, read_strobe, out_port, interrupt_ack,
        output in_port, interrupt
    );

endinterface

// File: rtl/pico_io_sync.sv
// One 8-bit input channel: 2-flop synchroniser, previous-value register and change flag.
module pico_io_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] d_in,
    output logic [7:0] sync_out,
    output logic       change
);

    logic [7:0] meta_q, meta_d;
    logic [7:0] sync_q, sync_d;
    logic [7:0] prev_q, prev_d;

    // Shift the external value through the synchroniser into the previous-value register
    always_comb begin
        meta_d = d_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Synchroniser and previous-value flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 8'h00;
            sync_q <= 8'h00;
            prev_q <= 8'h00;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_out = sync_q;
    assign change   = (sync_q != prev_q);

endmodule

// File: rtl/pico_io_hub.sv
// pico_io_hub: KCPSM6 port decode, output registers, synchronised inputs and
// change-detect interrupts. Optional watchdog built when PICO_IO_WDOG_EN is defined.
module pico_io_hub
    import pico_io_pkg::*;
#(
    parameter int          N_OUT           = 4,
    parameter int          N_IN            = 4,
    parameter logic [7:0]  OUT_BASE        = 8'h00,
    parameter logic [7:0]  IN_BASE         = 8'h20,
    parameter logic [7:0]  IRQ_STATUS_PORT = IRQ_STATUS_PORT_DEF,
    parameter logic [7:0]  IRQ_MASK_PORT   = IRQ_MASK_PORT_DEF,
    parameter logic [7:0]  WDOG_PORT       = WDOG_PORT_DEF,
    parameter logic [23:0] WDOG_CYCLES     = 24'd1_000_000
) (
    input  logic               clk,
    input  logic               cpu_reset_n,
    pico_io_hub_if.slave       bus,
    input  logic [N_IN*8-1:0]  ch_in,
    output logic [N_OUT*8-1:0] ch_out,
    output logic [N_IN-1:0]    rd_pulse,
    output logic               wdog_reset
);

    logic [N_IN-1:0][7:0]  sync_ch;
    logic [N_IN-1:0]       change;

    logic [N_OUT-1:0][7:0] ch_out_q, ch_out_d;
    logic [7:0]            in_port_q, in_port_d;
    logic [N_IN-1:0]       rd_pulse_q, rd_pulse_d;
    logic [N_IN-1:0]       pending_q, pending_d;
    logic [N_IN-1:0]       mask_q, mask_d;
    logic [N_IN-1:0]       clr_bits;

    irq_state_e            state_q;
    logic                  irq_q;

    logic                  status_sel;
    logic                  mask_sel;
    logic                  wdog_sel;
    logic                  special_sel;
    logic [7:0]            wdog_rd_byte;

    for (genvar g = 0; g < N_IN; g++) begin : g_sync
        pico_io_sync u_sync (
            .clk      (clk),
            .rst_n    (cpu_reset_n),
            .d_in     (ch_in[8*g +: 8]),
            .sync_out (sync_ch[g]),
            .change   (change[g])
        );
    end

    assign status_sel  = (bus.port_id == IRQ_STATUS_PORT);
    assign mask_sel    = (bus.port_id == IRQ_MASK_PORT);
    // Special ports shadow any OUT/IN decode that happens to land on them
    assign special_sel = status_sel | mask_sel | wdog_sel;

`ifdef PICO_IO_WDOG_EN
    logic [23:0] wdog_cnt_q, wdog_cnt_d;
    logic [4:0]  pulse_cnt_q, pulse_cnt_d;
    logic        wdog_q, wdog_d;
    logic        kick;
    logic        expire;

    assign wdog_sel     = (bus.port_id == WDOG_PORT);
    assign kick         = bus.write_strobe & wdog_sel;
    // A kick landing on the terminal count wins and no pulse is started
    assign expire       = !kick && (wdog_cnt_q == 24'd0);
    assign wdog_rd_byte = wdog_cnt_q[23:16];
    assign wdog_reset   = wdog_q;

    // Timeout counter reload/decrement and fixed-length reset pulse; kicks never shorten a pulse
    always_comb begin
        wdog_cnt_d  = wdog_cnt_q - 24'd1;
        pulse_cnt_d = pulse_cnt_q;
        wdog_d      = wdog_q;
        if (kick || expire) begin
            wdog_cnt_d = WDOG_CYCLES - 24'd1;
        end
        if (expire) begin
            pulse_cnt_d = 5'(WDOG_PULSE_LEN - 1);
            wdog_d      = 1'b1;
        end else if (pulse_cnt_q != 5'd0) begin
            pulse_cnt_d = pulse_cnt_q - 5'd1;
        end else begin
            wdog_d      = 1'b0;
        end
    end

    // Watchdog flops
    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            wdog_cnt_q  <= WDOG_CYCLES - 24'd1;
            pulse_cnt_q <= 5'd0;
            wdog_q      <= 1'b0;
        end else begin
            wdog_cnt_q  <= wdog_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            wdog_q      <= wdog_d;
        end
    end
`else
    assign wdog_sel     = 1'b0;
    assign wdog_rd_byte = 8'h00;
    assign wdog_reset   = 1'b0;
`endif

    // Output register loads from OUTPUT (base-relative) and OUTPUTK (low nibble index)
    always_comb begin
        ch_out_d = ch_out_q;
        for (int i = 0; i < N_OUT; i++) begin
            if (bus.write_strobe && !special_sel && (bus.port_id == OUT_BASE + 8'(i))) begin
                ch_out_d[i] = bus.out_port;
            end else if (bus.k_write_strobe && !bus.write_strobe && !special_sel &&
                         (bus.port_id[3:0] == 4'(i))) begin
                ch_out_d[i] = bus.out_port;
            end
        end
    end

    // Read mux and per-channel read pulses, registered every cycle from port_id
    always_comb begin
        in_port_d  = 8'h00;
        rd_pulse_d = '0;
        if (status_sel) begin
            in_port_d = 8'(pending_q);
        end else if (mask_sel) begin
            in_port_d = 8'(mask_q);
        end else if (wdog_sel) begin
            in_port_d = wdog_rd_byte;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (bus.port_id == IN_BASE + 8'(i)) begin
                    in_port_d     = sync_ch[i];
                    rd_pulse_d[i] = bus.read_strobe;
                end
            end
        end
    end

    // Mask writes and pending update; a new event beats a simultaneous write-1-to-clear
    always_comb begin
        clr_bits  = (bus.write_strobe && status_sel) ? bus.out_port[N_IN-1:0] : '0;
        pending_d = (pending_q & ~clr_bits) | (change & mask_q);
        mask_d    = (bus.write_strobe && mask_sel) ? bus.out_port[N_IN-1:0] : mask_q;
    end

    // Datapath and status flops
    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            ch_out_q   <= '0;
            in_port_q  <= 8'h00;
            rd_pulse_q <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
        end else begin
            ch_out_q   <= ch_out_d;
            in_port_q  <= in_port_d;
            rd_pulse_q <= rd_pulse_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
        end
    end

    // Interrupt handshake FSM with registered interrupt request
    always_ff @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|pending_q) begin
                        state_q <= REQ;
                        irq_q   <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.interrupt_ack) begin
                        state_q <= SERVICE;
                        irq_q   <= 1'b0;
                    end else if (pending_q == '0) begin
                        state_q <= IDLE;
                        irq_q   <= 1'b0;
                    end
                end
                SERVICE: begin
                    irq_q <= 1'b0;
                    if (pending_q == '0) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ch_out        = ch_out_q;
    assign rd_pulse      = rd_pulse_q;
    assign bus.in_port   = in_port_q;
    assign bus.interrupt = irq_q;

endmodule

// File: tb/tb_pico_io_hub.sv
// Self-checking bench for pico_io_hub: directed scenarios plus randomized bus traffic
// compared every cycle against a behavioural model. Watchdog scenarios when PICO_IO_WDOG_EN.
`timescale 1ns/1ps
module tb_pico_io_hub;

    localparam int N_OUT = 4;
    localparam int N_IN  = 4;
    localparam int WD    = 100;
    localparam logic [7:0] LOWMASK = 8'((1 << N_IN) - 1);

    logic clk = 1'b0;
    logic cpu_reset_n;
    always #5 clk = ~clk;

    pico_io_hub_if bus();
    logic [N_IN*8-1:0]  ch_in;
    logic [N_OUT*8-1:0] ch_out;
    logic [N_IN-1:0]    rd_pulse;
    logic               wdog_reset;

    pico_io_hub #(
        .N_OUT       (N_OUT),
        .N_IN        (N_IN),
        .WDOG_CYCLES (24'(WD))
    ) dut (
        .clk         (clk),
        .cpu_reset_n (cpu_reset_n),
        .bus         (bus),
        .ch_in       (ch_in),
        .ch_out      (ch_out),
        .rd_pulse    (rd_pulse),
        .wdog_reset  (wdog_reset)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]        m_out [N_OUT];
    logic [7:0]        m_mask, m_pend, m_in_port;
    logic [N_IN-1:0]   m_rd;
    logic [N_IN*8-1:0] m_seen [3];   // ch_in as sampled 3, 2 and 1 edges ago
    bit                m_irq, m_serv;
    int                m_since, m_pulse;

    task automatic model_reset();
        for (int i = 0; i < N_OUT; i++) m_out[i] <= 8'h00;
        for (int i = 0; i < 3; i++) m_seen[i] <= '0;
        m_mask <= 8'h00; m_pend <= 8'h00; m_in_port <= 8'h00; m_rd <= '0;
        m_irq <= 1'b0; m_serv <= 1'b0; m_since <= 0; m_pulse <= 0;
    endtask

    task automatic model_step();
        logic [7:0] port, chg, clr, rdv;
        logic [N_IN-1:0] rdp;
        bit sp, wd_on, trig;
        int idx;
`ifdef PICO_IO_WDOG_EN
        wd_on = 1'b1;
`else
        wd_on = 1'b0;
`endif
        port = bus.port_id;
        // the value the CPU can see lags the pin by two edges; a change is seen one edge later
        chg = 8'h00;
        for (int i = 0; i < N_IN; i++)
            if (m_seen[1][8*i +: 8] != m_seen[0][8*i +: 8]) chg[i] = 1'b1;
        sp = (port == 8'hF0) || (port == 8'hF1) || (wd_on && port == 8'hF2);

        rdv = 8'h00; rdp = '0;
        if (port == 8'hF0) rdv = m_pend;
        else if (port == 8'hF1) rdv = m_mask;
        else if (wd_on && port == 8'hF2) rdv = 8'((WD - 1 - m_since) >> 16);
        else if (port >= 8'h20 && port < 8'h20 + N_IN) begin
            idx = int'(port) - 32;
            rdv = m_seen[1][8*idx +: 8];
            rdp[idx] = bus.read_strobe;
        end
        m_in_port <= rdv;
        m_rd      <= rdp;

        clr = (bus.write_strobe && port == 8'hF0) ? bus.out_port : 8'h00;
        m_pend <= ((m_pend & ~clr) | (chg & m_mask)) & LOWMASK;
        if (bus.write_strobe && port == 8'hF1) m_mask <= bus.out_port & LOWMASK;

        if (bus.write_strobe && !sp && port < N_OUT) m_out[port] <= bus.out_port;
        else if (bus.k_write_strobe && !bus.write_strobe && !sp && port[3:0] < N_OUT)
            m_out[port[3:0]] <= bus.out_port;

        if (!m_irq && !m_serv) begin
            if (m_pend != 0) m_irq <= 1'b1;
        end else if (m_irq) begin
            if (bus.interrupt_ack) begin m_irq <= 1'b0; m_serv <= 1'b1; end
            else if (m_pend == 0) m_irq <= 1'b0;
        end else if (m_pend == 0) begin
            m_serv <= 1'b0;
        end

        trig = 1'b0;
        if (wd_on) begin
            if (bus.write_strobe && port == 8'hF2) m_since <= 0;
            else if (m_since == WD - 1) begin m_since <= 0; trig = 1'b1; end
            else m_since <= m_since + 1;
        end
        if (trig) m_pulse <= 16;
        else if (m_pulse > 0) m_pulse <= m_pulse - 1;

        m_seen[0] <= m_seen[1];
        m_seen[1] <= m_seen[2];
        m_seen[2] <= ch_in;
    endtask

    always @(posedge clk or negedge cpu_reset_n) begin
        if (!cpu_reset_n) model_reset();
        else model_step();
    end

    function automatic logic [N_OUT*8-1:0] m_out_packed();
        logic [N_OUT*8-1:0] v;
        for (int i = 0; i < N_OUT; i++) v[8*i +: 8] = m_out[i];
        return v;
    endfunction

    // lockstep comparison of every output, away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            check("ch_out", 32'(ch_out), 32'(m_out_packed()));
            check("in_port", 32'(bus.in_port), 32'(m_in_port));
            check("rd_pulse", 32'(rd_pulse), 32'(m_rd));
            check("interrupt", 32'(bus.interrupt), 32'(m_irq));
            check("wdog_reset", 32'(wdog_reset), 32'(m_pulse != 0));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_bus();
        bus.write_strobe = 1'b0; bus.k_write_strobe = 1'b0;
        bus.read_strobe = 1'b0;  bus.interrupt_ack = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] p, input logic [7:0] d);
        bus.port_id = p; bus.out_port = d; bus.write_strobe = 1'b1;
        @(negedge clk);
        bus.write_strobe = 1'b0;
    endtask

    task automatic kwr(input logic [7:0] p, input logic [7:0] d);
        bus.port_id = p; bus.out_port = d; bus.k_write_strobe = 1'b1;
        @(negedge clk);
        bus.k_write_strobe = 1'b0;
    endtask

    task automatic rd(input logic [7:0] p, input string tag, input logic [7:0] exp);
        bus.port_id = p;
        @(negedge clk);
        check(tag, 32'(bus.in_port), 32'(exp));
    endtask

    task automatic do_reset();
        cpu_reset_n = 1'b0;
        cyc(2);
        cpu_reset_n = 1'b1;
    endtask

    function automatic logic [7:0] pick_port();
        case ($urandom_range(0, 7))
            0:       return 8'($urandom_range(0, 5));
            1:       return 8'(32 + $urandom_range(0, 5));
            2:       return 8'hF0;
            3:       return 8'hF1;
            4:       return 8'hF2;
            5:       return 8'($urandom);
            6:       return 8'(48 + $urandom_range(0, 7));
            default: return 8'h80;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.port_id = 8'h00; bus.out_port = 8'h00;
        idle_bus();
        ch_in = '0;
        cpu_reset_n = 1'b0;
        #12;
        check("rst_ch_out", 32'(ch_out), 32'h0);
        check("rst_in_port", 32'(bus.in_port), 32'h0);
        check("rst_rd_pulse", 32'(rd_pulse), 32'h0);
        check("rst_interrupt", 32'(bus.interrupt), 32'h0);
        check("rst_wdog", 32'(wdog_reset), 32'h0);
        @(negedge clk);
        cpu_reset_n = 1'b1;
        chk_on = 1'b1;

        // output decode
        wr(8'h02, 8'hA5);
        check("out_write", 32'(ch_out), 32'h00A5_0000);
        kwr(8'h31, 8'h3C);
        check("outk_write", 32'(ch_out), 32'h00A5_3C00);
        wr(8'h07, 8'h11);
        check("out_unmapped", 32'(ch_out), 32'h00A5_3C00);

        // read path
        ch_in[15:8] = 8'h5A;
        cyc(3);
        bus.port_id = 8'h21; bus.read_strobe = 1'b1;
        @(negedge clk);
        bus.read_strobe = 1'b0;
        check("rd_data", 32'(bus.in_port), 32'h5A);
        check("rd_pulse_on", 32'(rd_pulse), 32'b0010);
        @(negedge clk);
        check("rd_pulse_off", 32'(rd_pulse), 32'b0000);
        rd(8'h80, "rd_unmapped", 8'h00);

        // interrupt handshake
        wr(8'hF1, 8'h01);
        ch_in[7:0] = ~ch_in[7:0];
        cyc(4);
        check("irq_req", 32'(bus.interrupt), 32'h1);
        rd(8'hF0, "pend_set", 8'h01);
        bus.interrupt_ack = 1'b1;
        @(negedge clk);
        bus.interrupt_ack = 1'b0;
        check("irq_ack_drop", 32'(bus.interrupt), 32'h0);
        cyc(1);
        check("irq_service_quiet", 32'(bus.interrupt), 32'h0);
        wr(8'hF0, 8'h01);
        rd(8'hF0, "pend_w1c", 8'h00);
        ch_in[7:0] = ~ch_in[7:0];
        cyc(4);
        check("irq_after_idle", 32'(bus.interrupt), 32'h1);
        wr(8'hF0, 8'h01);
        cyc(1);
        check("irq_req_cleared", 32'(bus.interrupt), 32'h0);

        // masking and set/clear collision
        wr(8'hF1, 8'h00);
        ch_in[7:0] = ~ch_in[7:0];
        cyc(5);
        rd(8'hF0, "masked_no_pend", 8'h00);
        check("masked_no_irq", 32'(bus.interrupt), 32'h0);
        wr(8'hF1, 8'h01);
        ch_in[7:0] = ~ch_in[7:0];
        cyc(2);
        wr(8'hF0, 8'h01);
        rd(8'hF0, "set_beats_clr", 8'h01);
        wr(8'hF1, 8'h00);
        rd(8'hF0, "unmask_keeps_pend", 8'h01);
        rd(8'hF1, "mask_read", 8'h00);
        wr(8'hF0, 8'hFF);
        cyc(2);

        // asynchronous reset mid-operation
        wr(8'h00, 8'hFF);
        wr(8'hF1, 8'h01);
        ch_in[7:0] = ~ch_in[7:0];
        cyc(5);
        check("pre_rst_irq", 32'(bus.interrupt), 32'h1);
        #2 cpu_reset_n = 1'b0;
        #1;
        check("async_rst_irq", 32'(bus.interrupt), 32'h0);
        check("async_rst_ch_out", 32'(ch_out), 32'h0);
        check("async_rst_in_port", 32'(bus.in_port), 32'h0);
        @(negedge clk);
        cpu_reset_n = 1'b1;
        rd(8'hF0, "rst_pend", 8'h00);
        rd(8'hF1, "rst_mask", 8'h00);

`ifdef PICO_IO_WDOG_EN
        // watchdog free-running timeout
        do_reset();
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (k == 99)  check("wd_before", 32'(wdog_reset), 32'h0);
            if (k == 100) check("wd_start", 32'(wdog_reset), 32'h1);
            if (k == 115) check("wd_last", 32'(wdog_reset), 32'h1);
            if (k == 116) check("wd_end", 32'(wdog_reset), 32'h0);
        end
        // kick postpones the timeout
        do_reset();
        for (int k = 1; k <= 152; k++) begin
            bus.port_id = 8'hF2;
            bus.write_strobe = (k == 50);
            @(negedge clk);
            if (k == 100) check("wd_kick_100", 32'(wdog_reset), 32'h0);
            if (k == 149) check("wd_kick_149", 32'(wdog_reset), 32'h0);
            if (k == 150) check("wd_kick_150", 32'(wdog_reset), 32'h1);
        end
        bus.write_strobe = 1'b0;
`else
        // without the watchdog its port is plain unmapped space
        wr(8'hF2, 8'h77);
        rd(8'hF2, "wd_port_unmapped", 8'h00);
        check("wd_tied_low", 32'(wdog_reset), 32'h0);
`endif

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            int r;
            int idx;
            r = $urandom_range(0, 99);
            bus.port_id        = pick_port();
            bus.out_port       = 8'($urandom);
            bus.write_strobe   = (r < 20);
            bus.k_write_strobe = (r >= 20 && r < 28);
            bus.read_strobe    = ($urandom_range(0, 3) == 0);
            bus.interrupt_ack  = m_irq ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 4) == 0) begin
                idx = $urandom_range(0, N_IN - 1);
                ch_in[8*idx +: 8] = 8'($urandom);
            end
            @(negedge clk);
        end

        idle_bus();
        cyc(2);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pico_io_hub.md
Name: pico_io_hub

Overview:
- Parametrised I/O and interrupt subsystem for the KCPSM6 processor subsystem; replaces hard-wired port glue around the processor.
- Decodes port_id into N_OUT output registers and N_IN synchronised input channels, and drives the registered in_port mux back to the CPU.
- Adds per-channel change-detect interrupts with mask, pending and write-1-to-clear status, plus a KCPSM6-compatible interrupt/interrupt_ack handshake.

Parameters:
- N_OUT, 4: number of 8-bit output registers (1..16).
- N_IN, 4: number of 8-bit input channels (1..8).
- OUT_BASE, 8'h00: port_id of output register 0; register i sits at OUT_BASE+i.
- IN_BASE, 8'h20: port_id of input channel 0; channel i sits at IN_BASE+i.
- IRQ_STATUS_PORT, 8'hF0: pending status (read), write-1-to-clear (write).
- IRQ_MASK_PORT, 8'hF1: interrupt mask, read/write.
- WDOG_PORT, 8'hF2: watchdog kick port (optional feature only).
- WDOG_CYCLES, 24'd1_000_000: watchdog timeout in clk cycles.

Ports:
- clk  input  1  system clock.
- cpu_reset_n  input  1  asynchronous active-low reset.
- port_id  input  8  KCPSM6 port address.
- write_strobe  input  1  OUTPUT strobe.
- k_write_strobe  input  1  OUTPUTK strobe.
- read_strobe  input  1  INPUT strobe.
- out_port  input  8  KCPSM6 write data.
- in_port  output  8  registered read data to KCPSM6.
- interrupt  output  1  interrupt request to KCPSM6.
- interrupt_ack  input  1  KCPSM6 interrupt acknowledge.
- ch_in  input  N_IN*8  asynchronous external inputs; channel i = bits [8i+7:8i].
- ch_out  output  N_OUT*8  output register contents.
- rd_pulse  output  N_IN  one-cycle pulse, registered, when channel i is read.
- wdog_reset  output  1  watchdog reset request, active high.

Behaviour:
- Reset values: ch_out, in_port, rd_pulse, pending and mask are 0; interrupt=0; wdog_reset=0; FSM in IDLE; sync flops and previous-value registers are 0.
- Write: on write_strobe, with port_id==OUT_BASE+i and i<N_OUT, ch_out[i] is loaded with out_port on the next edge.
- OUTPUTK: on k_write_strobe, the index is port_id[3:0] and the base is ignored. Indices >= N_OUT are ignored.
- IRQ ports take precedence over any overlapping OUT/IN decode. Unmapped ports: writes are dropped and reads return 8'h00.
- Read mux: in_port is registered every cycle from port_id, giving 1-cycle latency; KCPSM6 holds port_id for 2 cycles.
  - IN_BASE+i returns sync_ch[i].
  - IRQ_STATUS_PORT returns pending, zero-extended.
  - IRQ_MASK_PORT returns mask.
- rd_pulse[i] asserts for exactly one cycle after a read_strobe cycle addressing channel i.
- Input sync: each channel uses a 2-flop synchroniser followed by a prev register. change[i] = (sync!=prev) for one cycle. Latency from a ch_in change to pending set is 3 edges.
- Pending: pending[i] is set when change[i] & mask[i]. A write to IRQ_STATUS_PORT clears the bits where out_port=1.
  - Simultaneous set and clear of the same bit: set wins.
  - Clearing a mask bit does not clear its pending bit.
- Interrupt FSM:
  - IDLE: interrupt=0. Goes to REQ when |pending.
  - REQ: interrupt=1, held until interrupt_ack. On interrupt_ack goes to SERVICE and interrupt drops on the same edge.
  - SERVICE: interrupt=0. New events accumulate in pending but are not signalled. Returns to IDLE when pending==0.
  - If pending becomes 0 while in REQ (software cleared it with interrupts masked in the CPU), the FSM returns to IDLE and interrupt drops.
- Async reset mid-transaction immediately forces the reset values above; no partial write survives.

Optional Feature:
- Macro PICO_IO_WDOG_EN.
- Defined: a 24-bit down-counter is loaded with WDOG_CYCLES-1 at reset and on any write_strobe to WDOG_PORT (data ignored). It decrements every cycle.
  - On reaching 0, wdog_reset pulses high for 16 cycles and the counter reloads.
  - A kick during the pulse does not shorten it.
  - Reading WDOG_PORT returns counter[23:16].
- Not defined: wdog_reset is tied 0, no counter is built, and WDOG_PORT is unmapped.

Decomposition:
- Package pico_io_pkg: default port constants (IRQ_STATUS_PORT, IRQ_MASK_PORT, WDOG_PORT), FSM state typedef {IDLE, REQ, SERVICE}, and the wdog pulse length constant 16.
- Sub-module pico_io_sync: one 8-bit channel with 2-flop synchroniser, prev register and change output, instantiated N_IN times by generate.

Test Plan:
- Output decode: write_strobe, port_id=8'h02, out_port=8'hA5 -> ch_out[2]=A5 next edge, others unchanged. k_write_strobe, port_id=8'h31, data 8'h3C -> ch_out[1]=3C.
- Read path: ch_in[1]=8'h5A for ≥3 cycles, then port_id=8'h21 -> in_port=5A one cycle later. read_strobe -> rd_pulse=4'b0010 for exactly one cycle. port_id=8'h80 -> in_port=00.
- Interrupt handshake: mask=8'h01, toggle ch_in[0] -> pending=01 and interrupt=1. Hold interrupt_ack one cycle -> interrupt=0 and SERVICE. Write 8'h01 to 8'hF0 -> pending=0, then IDLE.
- Masking/collision: mask=0, toggle ch_in[0] -> no pending. mask=01; change[0] in the same cycle as a W1C of bit 0 -> pending[0]=1.
- Reset mid-op: assert cpu_reset_n=0 while in REQ with ch_out[0]=FF -> interrupt, ch_out and pending are 0 immediately, without waiting for a clock edge.
- With PICO_IO_WDOG_EN and WDOG_CYCLES=100:
  - No kick -> wdog_reset high on cycle 100 for 16 cycles.
  - Kick at cycle 50 -> no pulse before cycle 150.
